koa_mult_sequencer: RTL

- Two-requester controller that shares one pipelined RecursiveKOA multiplier instance.
- Arbitrates operand requests round-robin and holds the operands stable for the multiplier's pipeline latency.
- Pulses the multiplier's load_b_i (result-register load), captures the product and returns it with the requester ID over a valid/ready handshake.
- Sits between the FPU mantissa-multiply clients and the KOA datapath.

---
 rtl/koa_mult_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/koa_mult_sequencer.sv
// koa_mult_sequencer
// Shares one pipelined RecursiveKOA multiplier between two requesters.
// A round-robin arbiter accepts one operand pair at a time, holds it on the
// multiplier inputs for LAT cycles, pulses the multiplier's result-register
// load, captures the product and returns it with the owner's ID over a
// valid/ready handshake.
//
// Parameters: SW  operand width (must match the multiplier)
//             LAT operand hold cycles before the result register is loaded
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   reqN_valid_i/ready_o        requester N handshake (N = 0, 1)
//   reqN_a_i/b_i                requester N operands
//   mul_a_o/mul_b_o             registered operands to Data_A_i/Data_B_i
//   mul_load_o                  to multiplier load_b_i
//   mul_result_i                from multiplier sgf_result_o
//   rsp_valid_o/ready_i         response handshake
//   rsp_id_o/rsp_result_o       owner ID and registered product
//   busy_o                      high whenever the FSM is not idle
// Optional build macro KOA_SEQ_PERF_EN adds op_count_o and stall_count_o
// (saturating 16-bit counters of response handshakes and stalled RESP cycles).
//
// state   | meaning
// IDLE    | arbitrating, ready asserted to the granted requester
// COMPUTE | operands held while the KOA pipeline fills (LAT cycles)
// LOAD    | mul_load_o pulsed, operands still held
// CAPTURE | multiplier result register sampled into rsp_result_o
// RESP    | rsp_valid_o high until the consumer accepts
module koa_mult_sequencer #(
  parameter int SW  = 24,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [SW-1:0]   req0_a_i,
  input  logic [SW-1:0]   req0_b_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [SW-1:0]   req1_a_i,
  input  logic [SW-1:0]   req1_b_i,
  output logic [SW-1:0]   mul_a_o,
  output logic [SW-1:0]   mul_b_o,
  output logic            mul_load_o,
  input  logic [2*SW-1:0] mul_result_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_id_o,
  output logic [2*SW-1:0] rsp_result_o,
  output logic            busy_o
`ifdef KOA_SEQ_PERF_EN
  ,
  output logic [15:0]     op_count_o,
  output logic [15:0]     stall_count_o
`endif
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPUTE,
    S_LOAD,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              favour_q, favour_d;
  logic [SW-1:0]     a_q, a_d, b_q, b_d;
  logic              id_q, id_d;
  logic [2*SW-1:0]   res_q, res_d;
  logic              any_req, grant, accept;

  always_comb begin
    any_req = req0_valid_i | req1_valid_i;
    // On a tie the favoured requester (the one not granted last) wins.
    grant   = (req0_valid_i && req1_valid_i) ? favour_q : req1_valid_i;
    // Grant is only offered to a valid requester, so ready implies handshake.
    accept  = (state_q == S_IDLE) && any_req;
    req0_ready_o = accept && !grant;
    req1_ready_o = accept && grant;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    favour_d = favour_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    res_d    = res_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d      = grant ? req1_a_i : req0_a_i;
          b_d      = grant ? req1_b_i : req0_b_i;
          id_d     = grant;
          favour_d = ~grant;
          cnt_d    = CW'(LAT - 1);
          state_d  = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (cnt_q == '0) state_d = S_LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_LOAD:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        res_d   = mul_result_i;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      favour_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      favour_q <= favour_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      res_q    <= res_d;
    end
  end

  assign mul_a_o      = a_q;
  assign mul_b_o      = b_q;
  assign mul_load_o   = (state_q == S_LOAD);
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = res_q;
  assign busy_o       = (state_q != S_IDLE);

`ifdef KOA_SEQ_PERF_EN
  logic [15:0] op_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else if (state_q == S_RESP) begin
      if (rsp_ready_i && op_cnt_q != 16'hFFFF)
        op_cnt_q <= op_cnt_q + 16'd1;
      if (!rsp_ready_i && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign op_count_o    = op_cnt_q;
  assign stall_count_o = stall_cnt_q;
`endif

endmodule
